// File: rtl/adder_tree_sched.sv
// Round-robin scheduler sharing one unclocked 8-operand adder tree between
// neuron channels, accumulating multi-beat partial sums per transaction.
module adder_tree_sched #(
  parameter int N       = 8,
  parameter int NIN     = 8,
  parameter int NREQ    = 4,
  parameter int SETTLE  = 2,
  parameter int MAXBEAT = 16,
  parameter int ACCW    = 15,
  parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [NIN*N-1:0]  op_data,
  input  logic              op_last,
  output logic [NIN*N-1:0]  tree_in,
  input  logic [N+2:0]      tree_sum,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACCW-1:0]   res_data,
  output logic [IDW-1:0]    res_id,
  output logic              res_err,
  output logic              busy
);

  localparam int BW = $clog2(MAXBEAT) + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LOAD,
    S_WAIT,
    S_ACC,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [NREQ-1:0]  r_gnt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_owner;
  logic [ACCW-1:0]  r_acc;
  logic [BW-1:0]    r_beat;
  logic [SW-1:0]    r_wcnt;
  logic [NIN*N-1:0] r_tree_in;
  logic             r_last;
  logic             r_forced;
  logic             r_err;
  logic             r_op_ready;
  logic             r_res_valid;
  logic             r_busy;

  logic [IDW-1:0]   w_pick;
  logic [NREQ-1:0]  w_gnt;
  logic             w_found;
  logic             w_cap;
  logic [IDW-1:0]   w_next_ptr;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    int k;
    k       = 0;
    w_pick  = '0;
    w_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(r_ptr) + i) % NREQ;
      if (!w_found && req[k]) begin
        w_found = 1'b1;
        w_pick  = IDW'(k);
      end
    end
  end

  always_comb begin
    w_gnt         = '0;
    w_gnt[w_pick] = 1'b1;
  end

  assign w_cap = (r_beat == BW'(MAXBEAT - 1));

  assign w_next_ptr = (r_owner == IDW'(NREQ - 1)) ?
                      '0 : r_owner + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_acc       <= '0;
      r_beat      <= '0;
      r_wcnt      <= '0;
      r_tree_in   <= '0;
      r_last      <= 1'b0;
      r_forced    <= 1'b0;
      r_err       <= 1'b0;
      r_op_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_state <= S_ARB;
            r_busy  <= 1'b1;
          end
        end
        S_ARB: begin
          if (w_found) begin
            r_gnt      <= w_gnt;
            r_owner    <= w_pick;
            r_acc      <= '0;
            r_beat     <= '0;
            r_err      <= 1'b0;
            r_op_ready <= 1'b1;
            r_state    <= S_LOAD;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (op_valid) begin
            r_tree_in  <= op_data;
            r_last     <= op_last || w_cap;
            r_forced   <= !op_last && w_cap;
            r_beat     <= r_beat + 1'b1;
            r_wcnt     <= '0;
            r_op_ready <= 1'b0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Tree is combinational; give it SETTLE cycles on stable inputs.
          if (r_wcnt == SW'(SETTLE - 1)) begin
            r_state <= S_ACC;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        S_ACC: begin
          r_acc <= r_acc + ACCW'(tree_sum);
          if (r_last) begin
            r_err       <= r_forced;
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_op_ready <= 1'b1;
            r_state    <= S_LOAD;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_gnt       <= '0;
            r_ptr       <= w_next_ptr;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign op_ready  = r_op_ready;
  assign tree_in   = r_tree_in;
  assign res_valid = r_res_valid;
  assign res_data  = r_acc;
  assign res_id    = r_owner;
  assign res_err   = r_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_adder_tree_sched.sv
// Directed bench for adder_tree_sched with a behavioural adder tree
// feeding tree_sum from tree_in.
module tb_adder_tree_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        op_valid;
  logic        op_ready;
  logic [63:0] op_data;
  logic        op_last;
  logic [63:0] tree_in;
  logic [10:0] tree_sum;
  logic        res_valid;
  logic        res_ready;
  logic [14:0] res_data;
  logic [1:0]  res_id;
  logic        res_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_cnt = 0;

  adder_tree_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_data   (op_data),
    .op_last   (op_last),
    .tree_in   (tree_in),
    .tree_sum  (tree_sum),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_err   (res_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (op_ready) rdy_cnt <= rdy_cnt + 1;

  always_comb begin
    tree_sum = '0;
    for (int k = 0; k < 8; k++)
      tree_sum = tree_sum + 11'(tree_in[k*8 +: 8]);
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last);
    int n = 0;
    while (!op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      errors++;
      $error("FAIL op_ready_timeout got 0 exp 1");
    end
    op_valid = 1'b1;
    op_data  = d;
    op_last  = last;
    @(negedge clk);
    op_valid = 1'b0;
    op_last  = 1'b0;
  endtask

  task automatic wait_res();
    int n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      errors++;
      $error("FAIL res_timeout got 0 exp 1");
    end
  endtask

  task automatic take_res(input logic [3:0] req_after);
    res_ready = 1'b1;
    req = req_after;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_drop", res_valid, 1'b0);
  endtask

  initial begin
    int c0;
    int r0;
    rst_n = 1'b0;
    req = '0;
    op_valid = 1'b0;
    op_data = '0;
    op_last = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_op_ready", op_ready, 1'b0);
    chk("rst_tree_in", tree_in, 64'h0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 15'd0);
    chk("rst_res_err", res_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single beat, latency
    req = 4'b0001;
    c0 = cyc;
    send_beat(64'h00FF00FF00FF00FF, 1'b1);
    wait_res();
    chk("t1_latency", 64'(cyc - c0), 64'd6);
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_data", res_data, 15'd1020);
    chk("t1_id", res_id, 2'd0);
    chk("t1_err", res_err, 1'b0);
    take_res(4'b0000);
    chk("t1_gnt_drop", gnt, 4'b0000);

    // 2: channel 2, three beats
    @(negedge clk);
    r0 = rdy_cnt;
    req = 4'b0100;
    send_beat(64'hFFFFFFFFFFFFFFFF, 1'b0);
    send_beat(64'h0101010101010101, 1'b0);
    send_beat(64'h0000000000000000, 1'b1);
    wait_res();
    chk("t2_data", res_data, 15'd2048);
    chk("t2_id", res_id, 2'd2);
    chk("t2_gnt", gnt, 4'b0100);
    chk("t2_ready_cnt", 64'(rdy_cnt - r0), 64'd3);
    take_res(4'b0000);

    // 3: simultaneous requests after reset, pointer wrap
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req = 4'b0011;
    send_beat(64'h0101010101010101, 1'b1);
    wait_res();
    chk("t3a_id", res_id, 2'd0);
    chk("t3a_data", res_data, 15'd8);
    take_res(4'b0011);
    send_beat(64'h0202020202020202, 1'b1);
    wait_res();
    chk("t3b_id", res_id, 2'd1);
    chk("t3b_gnt", gnt, 4'b0010);
    chk("t3b_data", res_data, 15'd16);
    take_res(4'b0011);
    send_beat(64'h0303030303030303, 1'b1);
    wait_res();
    chk("t3c_id", res_id, 2'd0);
    chk("t3c_data", res_data, 15'd24);
    take_res(4'b0000);

    // 4: result back-pressure, pointer is now 1
    @(negedge clk);
    req = 4'b0010;
    send_beat(64'h0A0A0A0A0A0A0A0A, 1'b1);
    wait_res();
    req = 4'b1010;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_valid", res_valid, 1'b1);
      chk("t4_data", res_data, 15'd80);
      chk("t4_gnt", gnt, 4'b0010);
    end
    take_res(4'b1000);
    send_beat(64'h0000000000000005, 1'b1);
    wait_res();
    chk("t4_next_gnt", gnt, 4'b1000);
    chk("t4_next_id", res_id, 2'd3);
    chk("t4_next_data", res_data, 15'd5);
    take_res(4'b0000);

    // 5: forced end at MAXBEAT, pointer is now 0
    @(negedge clk);
    req = 4'b0001;
    for (int b = 0; b < 16; b++)
      send_beat(64'hFFFFFFFFFFFFFFFF, 1'b0);
    wait_res();
    chk("t5_data", res_data, 15'd32640);
    chk("t5_err", res_err, 1'b1);
    chk("t5_id", res_id, 2'd0);
    take_res(4'b0000);

    // 6: reset during WAIT of beat 2
    @(negedge clk);
    req = 4'b0010;
    send_beat(64'h1111111111111111, 1'b0);
    send_beat(64'h2222222222222222, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_gnt", gnt, 4'b0000);
    chk("t6_tree_in", tree_in, 64'h0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_res_valid", res_valid, 1'b0);
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t6_no_result", res_valid, 1'b0);
    req = 4'b0001;
    send_beat(64'h0202020202020202, 1'b1);
    wait_res();
    chk("t6_fresh_data", res_data, 15'd16);
    chk("t6_fresh_id", res_id, 2'd0);
    take_res(4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_tree_sched.md
Name: adder_tree_sched

Overview:
- Round-robin scheduler that shares one 8-operand transmission-gate adder tree (8 x 8-bit -> 11-bit sum) between NREQ neuron channels.
- Accumulates multi-beat partial sums so a neuron with more than 8 synapses can use the same tree.
- Waits a programmable number of settle cycles per beat because the tree is unclocked.
- Sits between the synapse-weight fetch logic and the neuron membrane/threshold stage.

Parameters:
N, 8, operand width in bits.
NIN, 8, operands per beat (tree inputs).
NREQ, 4, number of requesting channels.
SETTLE, 2, clock cycles allowed for the tree to settle after its inputs change (>=1).
MAXBEAT, 16, maximum beats per transaction.
ACCW, 15, accumulator width (N+3+log2(MAXBEAT)).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req  in  NREQ  per-channel request, level.
gnt  out  NREQ  one-hot grant; zero when no owner.
op_valid  in  1  granted channel presents a beat.
op_ready  out  1  scheduler accepts the beat.
op_data  in  NIN*N  beat operands; operand k in bits [k*N +: N].
op_last  in  1  final beat of the transaction.
tree_in  out  NIN*N  registered operands driving the adder tree.
tree_sum  in  N+3  adder tree result.
res_valid  out  1  result available.
res_ready  in  1  consumer accepts the result.
res_data  out  ACCW  accumulated sum.
res_id  out  log2(NREQ)  channel the result belongs to.
res_err  out  1  transaction truncated at MAXBEAT.
busy  out  1  FSM not in IDLE.

Behaviour:
Reset (async, rst_n=0):
- All outputs, the accumulator and the beat counter go to 0.
- FSM goes to IDLE; round-robin pointer is set so channel 0 has highest priority.
- Reset asserted mid-transaction discards the transaction. No result is produced.

FSM IDLE -> ARB -> LOAD -> WAIT -> ACC -> (LOAD | DONE) -> IDLE.
- IDLE: if req != 0, go to ARB.
- ARB: pick the first requesting channel at or after the pointer (wrapping). Register gnt one-hot, clear the accumulator, clear the beat counter, go to LOAD.
- gnt holds from ARB exit until the DONE handshake. The owner deasserting req mid-transaction is ignored.
- LOAD: op_ready=1. On op_valid&&op_ready:
  - latch op_data into tree_in;
  - latch the last flag as op_last || (beat counter == MAXBEAT-1);
  - increment the beat counter;
  - go to WAIT.
- WAIT: hold for exactly SETTLE cycles. tree_in stays stable.
- ACC (1 cycle): acc <= acc + zero-extended tree_sum, unsigned, no saturation (ACCW cannot overflow within MAXBEAT beats).
  - If last is set, go to DONE; otherwise go to LOAD.
  - If last was forced by the counter with op_last=0, set the error flag.
- DONE: res_valid=1 with res_data=acc, res_id=owner and res_err=flag, all stable while res_valid is high.
  - On res_ready: drop gnt, set pointer = owner+1 mod NREQ, go to IDLE.
  - No new grant is issued while a result is pending.
- op_ready=0 in every state other than LOAD.
- tree_in keeps its last value outside LOAD, so the tree does not toggle and waste power.

Latency and throughput:
- Per beat: 1 (LOAD accept) + SETTLE + 1 (ACC) cycles.
- res_valid rises the cycle after the final ACC.
- Minimum transaction, 1 beat with SETTLE=2: req to res_valid = 1 (IDLE) + 1 (ARB) + 1 + 2 + 1 = 6 cycles.

Simultaneous events:
- A req arriving while busy waits its round-robin turn.
- Several requests asserted together are resolved purely by the pointer.

Test Plan:
1. After reset, req=4'b0001, one beat of alternating 0xFF/0x00 operands, op_last=1 -> gnt=0001; res_data=1020, res_id=0, res_err=0; res_valid exactly 6 cycles after req.
2. Channel 2, three beats: all 0xFF, all 0x01, all 0x00, op_last on beat 3 -> res_data=2048, res_id=2; op_ready high exactly once per beat.
3. req=4'b0011 simultaneously after reset, both hold req -> channel 0 served first, then channel 1; channel 0 re-requests and is served after channel 1 (pointer wrap).
4. res_ready held low 10 cycles in DONE -> res_valid, res_data and gnt stable; a req on another channel gets no grant until res_ready=1.
5. 16 beats of all 0xFF with op_last never asserted -> forced end after beat 16; res_data=32640, res_err=1.
6. rst_n pulsed low during WAIT of beat 2 -> gnt, tree_in, busy and res_valid go to 0 immediately; no result; next req is served from a zero accumulator.
